// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_arb_pkg
// Purpose  : Shared state encoding and default bus widths for wb_arbiter2.
// Revision : 1.0
// ============================================================================
package wb_arb_pkg;

    localparam int ARB_DATA_WIDTH = 16;
    localparam int ARB_ADDR_WIDTH = 32;
    localparam int ARB_SEL_WIDTH  = 2;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_M0   = 2'b01,
        ARB_M1   = 2'b10
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_arb_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module   : wb_arb_starve_ctr
// Purpose  : Saturating count of cycles master 1 has waited for the bus.
// Revision : 1.0
// ============================================================================
module wb_arb_starve_ctr #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic starved
);

    localparam int CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(LIMIT);

    logic [CNT_W-1:0] r_cnt;

    // Clear wins over increment so a grant always restarts the wait from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != C_LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign starved = (r_cnt == C_LIMIT);

endmodule
`default_nettype wire

// File: rtl/wb_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter2
// Purpose  : Two-master Wishbone arbiter, cyc-framed grants, CPU (m0) priority.
//            Define WB_ARB_FAIRNESS_EN to promote a starved master 1.
// Revision : 1.0
// ============================================================================
module wb_arbiter2
    import wb_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = ARB_DATA_WIDTH,
    parameter int ADDR_WIDTH   = ARB_ADDR_WIDTH,
    parameter int SEL_WIDTH    = DATA_WIDTH / 8,
    parameter int STARVE_LIMIT = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [DATA_WIDTH-1:0] m0_dat_i,
    input  logic [SEL_WIDTH-1:0]  m0_sel_i,
    input  logic                  m0_we_i,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    output logic [DATA_WIDTH-1:0] m0_dat_o,
    output logic                  m0_ack_o,

    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [DATA_WIDTH-1:0] m1_dat_i,
    input  logic [SEL_WIDTH-1:0]  m1_sel_i,
    input  logic                  m1_we_i,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    output logic [DATA_WIDTH-1:0] m1_dat_o,
    output logic                  m1_ack_o,

    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [DATA_WIDTH-1:0] s_dat_o,
    output logic [SEL_WIDTH-1:0]  s_sel_o,
    output logic                  s_we_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    input  logic                  s_ack_i,

    output logic [1:0]            gnt_o
);

    arb_state_t r_state;
    arb_state_t w_state_next;
    logic       w_req0;
    logic       w_req1;
    logic       w_starved;

    assign w_req0 = m0_cyc_i & m0_stb_i;
    assign w_req1 = m1_cyc_i & m1_stb_i;

`ifdef WB_ARB_FAIRNESS_EN
    wb_arb_starve_ctr #(
        .LIMIT   (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk     (clk_i),
        .rst     (rst_i),
        .inc     (w_req1 && (r_state != ARB_M1)),
        .clr     ((w_state_next == ARB_M1) && (r_state != ARB_M1)),
        .starved (w_starved)
    );
`else
    assign w_starved = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Grants only change via IDLE, which enforces one turnaround cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_req1 && w_starved) begin
                    w_state_next = ARB_M1;
                end else if (w_req0) begin
                    w_state_next = ARB_M0;
                end else if (w_req1) begin
                    w_state_next = ARB_M1;
                end
            end
            ARB_M0: begin
                if (!m0_cyc_i) begin
                    w_state_next = ARB_IDLE;
                end
            end
            ARB_M1: begin
                if (!m1_cyc_i) begin
                    w_state_next = ARB_IDLE;
                end
            end
            default: w_state_next = ARB_IDLE;
        endcase
    end

    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        case (r_state)
            ARB_M0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_we_o   = m0_we_i;
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                m0_ack_o = s_ack_i;
            end
            ARB_M1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_we_o   = m1_we_i;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                m1_ack_o = s_ack_i;
            end
            default: ;
        endcase
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign gnt_o    = {r_state == ARB_M1, r_state == ARB_M0};

endmodule
`default_nettype wire
